// File: rtl/rx_control_module.sv
// -----------------------------------------------------------------------------
// rx_control_module
// UART receiver for frames of: start bit, 8 data bits sent LSB first, one
// parity bit and one stop bit. Bit timing is derived from sysclk. The line is
// sampled at the middle of each bit.
//
// Parameters
//   CLK_DIV      sysclk cycles per bit (must be >= 4)
//   PARITY_MODE  expected XOR of the data bits and the parity bit (0 = even)
//
// Ports
//   sysclk       system clock
//   rst          synchronous active-high reset
//   rx_en_sig    receive enable; low aborts any frame and holds IDLE
//   rx           asynchronous serial input, idles high
//   rx_data      last received byte, held until the next done pulse
//   rx_done_sig  one-cycle pulse when a frame completes
//   parity_err   parity mismatch on the last frame
//   frame_err    stop bit was low on the last frame
//   rx_busy      high while a frame is being received
// -----------------------------------------------------------------------------
module rx_control_module #(
    parameter int   CLK_DIV     = 5208,
    parameter logic PARITY_MODE = 1'b0
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       rx_en_sig,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done_sig,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Running parity step; with the received parity bit as bit_v the result
    // is 1 exactly when the frame parity is wrong.
    function automatic logic parity_fold(input logic acc, input logic bit_v);
        return acc ^ bit_v;
    endfunction

    rx_state_t        state_r, state_nx;
    logic             rx_meta_r, rx_s, rx_d;
    logic             fall_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx;
    logic [2:0]       bidx_r, bidx_nx;
    logic [7:0]       shift_r, shift_nx;
    logic             par_acc_r, par_acc_nx;
    logic             perr_pend_r, perr_pend_nx;
    logic [7:0]       data_nx;
    logic             done_nx, perr_nx, ferr_nx, busy_nx;

    assign fall_s = rx_d & ~rx_s;

    // Two-flop synchronizer for rx plus one history flop for edge detection.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
            rx_d      <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s      <= rx_meta_r;
            rx_d      <= rx_s;
        end
    end

    // FSM state register.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_nx     = state_r;
        cnt_nx       = cnt_r;
        bidx_nx      = bidx_r;
        shift_nx     = shift_r;
        par_acc_nx   = par_acc_r;
        perr_pend_nx = perr_pend_r;
        data_nx      = rx_data;
        done_nx      = 1'b0;
        perr_nx      = parity_err;
        ferr_nx      = frame_err;

        if (!rx_en_sig) begin
            state_nx = IDLE;
            cnt_nx   = CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fall_s) begin
                        state_nx = START;
                        cnt_nx   = CNT_ZERO;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                START: begin
                    if (cnt_r == CNT_HALF) begin
                        // A high line at mid-start is a glitch, not a frame.
                        if (rx_s) begin
                            state_nx = IDLE;
                        end else begin
                            state_nx   = DATA;
                            cnt_nx     = CNT_ZERO;
                            bidx_nx    = 3'd0;
                            par_acc_nx = PARITY_MODE;
                        end
                    end else begin
                        cnt_nx = cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_r == CNT_FULL) begin
                        cnt_nx     = CNT_ZERO;
                        shift_nx   = {rx_s, shift_r[7:1]};
                        par_acc_nx = parity_fold(par_acc_r, rx_s);
                        if (bidx_r == 3'd7) begin
                            state_nx = PARITY;
                        end else begin
                            bidx_nx = bidx_r + 3'd1;
                        end
                    end else begin
                        cnt_nx = cnt_r + CNT_ONE;
                    end
                end
                PARITY: begin
                    if (cnt_r == CNT_FULL) begin
                        cnt_nx       = CNT_ZERO;
                        perr_pend_nx = parity_fold(par_acc_r, rx_s);
                        state_nx     = STOP;
                    end else begin
                        cnt_nx = cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is seen.
                    if (cnt_r == CNT_FULL) begin
                        cnt_nx   = CNT_ZERO;
                        data_nx  = shift_r;
                        perr_nx  = perr_pend_r;
                        ferr_nx  = ~rx_s;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = CNT_ZERO;
                end
            endcase
        end

        busy_nx = (state_nx != IDLE);
    end

    // Datapath and registered outputs.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt_r       <= CNT_ZERO;
            bidx_r      <= 3'd0;
            shift_r     <= 8'h00;
            par_acc_r   <= 1'b0;
            perr_pend_r <= 1'b0;
            rx_data     <= 8'h00;
            rx_done_sig <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            cnt_r       <= cnt_nx;
            bidx_r      <= bidx_nx;
            shift_r     <= shift_nx;
            par_acc_r   <= par_acc_nx;
            perr_pend_r <= perr_pend_nx;
            rx_data     <= data_nx;
            rx_done_sig <= done_nx;
            parity_err  <= perr_nx;
            frame_err   <= ferr_nx;
            rx_busy     <= busy_nx;
        end
    end

endmodule

// File: tb/tb_rx_control_module.sv
module tb_rx_control_module;

    localparam int DIV = 16;

    logic       sysclk = 1'b0;
    logic       rst;
    logic       rx_en_sig;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done_sig;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    int         n_total = 0;
    int         n_bad   = 0;
    logic [9:0] rxq[$];
    logic       busy_seen;

    rx_control_module #(.CLK_DIV(DIV), .PARITY_MODE(1'b0)) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .rx_en_sig   (rx_en_sig),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_done_sig (rx_done_sig),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 sysclk = ~sysclk;

    // Record each completed frame as {parity_err, frame_err, rx_data}.
    always @(negedge sysclk) begin
        if (rx_done_sig) rxq.push_back({parity_err, frame_err, rx_data});
        if (rx_busy) busy_seen = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    // abort_kind: 0 none, 1 drop rx_en_sig mid bit 3, 2 assert rst mid bit 3
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int abort_kind);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            if (i == 4 && abort_kind != 0) begin
                tick(DIV / 2);
                if (abort_kind == 1) rx_en_sig = 1'b0;
                else rst = 1'b1;
                tick(DIV / 2);
            end else begin
                tick(DIV);
            end
        end
        rx = 1'b1;
        if (abort_kind != 0) begin
            rx_en_sig = 1'b1;
            rst       = 1'b0;
        end
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        logic [9:0] item;
        check_val({tag, "_ndone"}, rxq.size(), 1);
        if (rxq.size() > 0) begin
            item = rxq.pop_front();
            check_val({tag, "_data"}, item[7:0], d);
            check_val({tag, "_perr"}, item[9], pe);
            check_val({tag, "_ferr"}, item[8], fe);
        end
        check_val({tag, "_held"}, rx_data, d);
        rxq.delete();
    endtask

    initial begin
        rst = 1'b1; rx_en_sig = 1'b1; rx = 1'b1; busy_seen = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(2);
        check_val("rst_data", rx_data, 8'h00);
        check_val("rst_done", rx_done_sig, 1'b0);
        check_val("rst_perr", parity_err, 1'b0);
        check_val("rst_ferr", frame_err, 1'b0);
        check_val("rst_busy", rx_busy, 1'b0);

        send_frame(8'hA5, 1'b0, 1'b1, 0); tick(4);
        expect_frame("a5", 8'hA5, 1'b0, 1'b0);

        send_frame(8'h01, 1'b0, 1'b1, 0); tick(4);
        expect_frame("01_bad_par", 8'h01, 1'b1, 1'b0);
        check_val("01_perr_out", parity_err, 1'b1);

        send_frame(8'h03, 1'b0, 1'b1, 0); tick(4);
        expect_frame("03", 8'h03, 1'b0, 1'b0);

        send_frame(8'h3C, 1'b0, 1'b0, 0); tick(4);
        expect_frame("3c_frm", 8'h3C, 1'b0, 1'b1);
        check_val("3c_ferr_out", frame_err, 1'b1);

        // 4-cycle glitch on idle line
        busy_seen = 1'b0;
        rx = 1'b0; tick(4); rx = 1'b1; tick(30);
        check_val("glitch_ndone", rxq.size(), 0);
        check_val("glitch_busy_seen", busy_seen, 1'b1);
        check_val("glitch_busy_clr", rx_busy, 1'b0);
        check_val("glitch_data", rx_data, 8'h3C);
        check_val("glitch_ferr", frame_err, 1'b1);
        rxq.delete();

        // back-to-back frames
        send_frame(8'h55, 1'b0, 1'b1, 0);
        send_frame(8'hAA, 1'b0, 1'b1, 0);
        tick(4);
        check_val("b2b_ndone", rxq.size(), 2);
        if (rxq.size() == 2) begin
            check_val("b2b_first", rxq[0], {2'b00, 8'h55});
            check_val("b2b_second", rxq[1], {2'b00, 8'hAA});
        end
        rxq.delete();

        // enable dropped mid-frame
        send_frame(8'hF0, 1'b0, 1'b1, 1); tick(4);
        check_val("en_abort_ndone", rxq.size(), 0);
        check_val("en_abort_data", rx_data, 8'hAA);
        check_val("en_abort_busy", rx_busy, 1'b0);
        rxq.delete();
        send_frame(8'h81, 1'b0, 1'b1, 0); tick(4);
        expect_frame("after_en", 8'h81, 1'b0, 1'b0);

        // reset mid-frame
        send_frame(8'hC3, 1'b0, 1'b1, 2); tick(4);
        check_val("rst_abort_ndone", rxq.size(), 0);
        check_val("rst_abort_data", rx_data, 8'h00);
        check_val("rst_abort_perr", parity_err, 1'b0);
        check_val("rst_abort_ferr", frame_err, 1'b0);
        check_val("rst_abort_busy", rx_busy, 1'b0);
        rxq.delete();
        send_frame(8'h07, 1'b1, 1'b1, 0); tick(4);
        expect_frame("after_rst", 8'h07, 1'b0, 1'b0);

        // break: line held low far beyond one frame
        rx = 1'b0; tick(14 * DIV);
        check_val("break_busy_low", rx_busy, 1'b0);
        rx = 1'b1; tick(20);
        expect_frame("break", 8'h00, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_control_module.md
# rx_control_module

UART receive control block for the serial path: it recovers 8N-with-parity frames (start, 8 data bits LSB-first, one parity bit, one stop bit) from the asynchronous `rx` pin. It is the receive counterpart of the transmit control stage and uses the same frame format and parity convention. It presents each byte to downstream logic with a one-cycle done pulse and per-frame error flags. Bit timing is generated internally from `sysclk`, so no external baud tick is required.

## Interface
- `CLK_DIV`, 5208: sysclk cycles per bit (50 MHz / 9600). Must be ≥ 4.
- `PARITY_MODE`, 1'b0: expected XOR of the 8 data bits and the parity bit (0 = even parity).

- `sysclk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rx_en_sig`  in  1  receive enable. Low forces IDLE and aborts any frame in progress.
- `rx`  in  1  asynchronous serial line; idles high.
- `rx_data`  out  8  last received byte; held until the next `rx_done_sig`.
- `rx_done_sig`  out  1  one-cycle pulse when a frame completes. Valid even if an error flag is set.
- `parity_err`  out  1  parity mismatch on the last frame; updated with `rx_done_sig`.
- `frame_err`  out  1  stop bit sampled low on the last frame; updated with `rx_done_sig`.
- `rx_busy`  out  1  high from start detection until return to IDLE.

## Operation
- Input conditioning: `rx` passes through a 2-FF synchronizer (`rx_s`), followed by one history register (`rx_d`). Synchronizer and history reset to 1. A falling edge is `rx_d & ~rx_s`.
- Internal state: bit-time counter `cnt` (width clog2(CLK_DIV)), bit index `bidx` (0..7), shift register, and running parity.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `rx_busy`=0. On falling edge with `rx_en_sig`=1: go to START, `cnt`←0.
  - START: when `cnt`==CLK_DIV/2−1, sample `rx_s`.
    - Sample 1 (glitch/false start): go to IDLE; no done pulse, no flag change.
    - Sample 0: go to DATA with `cnt`←0, `bidx`←0, parity accumulator←`PARITY_MODE`.
  - DATA: when `cnt`==CLK_DIV−1, sample `rx_s` into bit `bidx`, XOR it into the accumulator, reset `cnt`. After `bidx`==7, go to PARITY.
  - PARITY: when `cnt`==CLK_DIV−1, sample. Error when sample ≠ accumulator, i.e. when `PARITY_MODE` ^ (XOR of data bits) ≠ parity bit. Go to STOP.
  - STOP: when `cnt`==CLK_DIV−1, sample. Then in the same clock edge:
    - `rx_data` ← shift register
    - `parity_err` ← parity result
    - `frame_err` ← ~sample
    - `rx_done_sig` ← 1
    - go to IDLE.
- Back-to-back frames: return to IDLE at mid-stop-bit, so the next frame's start edge is detected.
- `rx_en_sig` low in any non-IDLE state: go to IDLE on the next edge. `rx_data` and the flags are unchanged, and no done pulse is issued.
- `rst` high at any time: all state returns to IDLE and registers take their reset values on that edge. A frame in progress is discarded.
- A line held low (break) gives data 0x00 with `frame_err`=1. The block then waits for a new falling edge, so it does not retrigger while the line stays low.

## Timing
- Reset values:
  - `rx_data`=8'h00, `rx_done_sig`=0, `parity_err`=0, `frame_err`=0, `rx_busy`=0.
  - FSM=IDLE, `rx_s`=`rx_d`=1.
- Pin-to-edge-detect latency: 2 cycles (synchronizer), plus 1 cycle for the history register.
- Counting from the edge-detect cycle t0:
  - start sampled at t0+CLK_DIV/2
  - data bit n (n = 0..7) sampled at t0+CLK_DIV/2+(n+1)·CLK_DIV
  - parity sampled at +9·CLK_DIV
  - stop sampled at +10·CLK_DIV
- `rx_done_sig` and the new `rx_data`/flags are registered at the stop-sample edge. They are visible in the cycle after it, and `rx_done_sig` is high for exactly one cycle.
- `rx_busy` rises the cycle after t0 and falls together with the `rx_done_sig` assertion.
- No backpressure: downstream must capture `rx_data` before the next `rx_done_sig`; the block overwrites it without warning.

## Test plan
- CLK_DIV=16, PARITY_MODE=0. Send 0xA5 with parity bit 0 and stop 1 -> exactly one `rx_done_sig`; `rx_data`=0xA5, `parity_err`=0, `frame_err`=0.
- Send 0x01 with parity bit 0 (wrong) -> `rx_data`=0x01, `parity_err`=1, `frame_err`=0. Then send 0x03 with parity 0 -> `parity_err` returns to 0.
- Send 0x3C with correct parity and stop bit 0 -> `frame_err`=1, `rx_data`=0x3C.
- Drive a 4-cycle low glitch on an idle line -> no `rx_done_sig`; `rx_busy` pulses then clears by cycle t0+8+1; outputs unchanged.
- Send 0x55 and 0xAA back-to-back, with the next start edge immediately after the stop bit -> two done pulses carrying 0x55 then 0xAA, no errors.
- Mid-frame aborts, tested separately:
  - `rx_en_sig` low during bit 3 -> no done; `rx_data` keeps its prior value; next frame received correctly.
  - `rst` asserted during bit 3 -> all outputs return to reset values; next frame received correctly.
